// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: opcode/funct constants, ALU and select encodings, control bundles for pipe_ctrl_unit
package pipe_ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2a;
  typedef enum logic [2:0] {
    ALU_ADDU = 3'd0,
    ALU_SUBU = 3'd1,
    ALU_OR   = 3'd2,
    ALU_AND  = 3'd3,
    ALU_SLT  = 3'd4
  } alu_op_e;
  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_e;
  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10
  } pc_sel_e;
  typedef struct packed {
    logic    regwr;
    logic    memtoreg;
    logic    memwr;
    logic    alusrc;
    alu_op_e aluctr;
    logic    extop;
    logic    branch;
    logic    branch_ne;
    logic    jump;
    logic    regdst;
    logic    use_rs;
    logic    use_rt;
    logic    illegal;
  } ctl_t;
  typedef struct packed {
    logic    regwr;
    logic    memtoreg;
    logic    memwr;
    logic    alusrc;
    alu_op_e aluctr;
    logic    branch;
    logic    branch_ne;
  } ex_ctl_t;
  localparam ctl_t    CTL_NOP = '0;
  localparam ex_ctl_t EX_NOP  = '0;
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: ID-stage fields, EX zero flag and all pipeline control outputs of pipe_ctrl_unit
//   slave  : control unit view (i_* in, o_* out)
//   master : datapath view (i_* out, o_* in)
interface pipe_ctrl_if #(
  parameter int ALUCTR_W = 3,
  parameter int RA_W     = 5
);
  logic [5:0]          i_op;
  logic [5:0]          i_funct;
  logic [RA_W-1:0]     i_rs;
  logic [RA_W-1:0]     i_rt;
  logic [RA_W-1:0]     i_rd;
  logic                i_zero;
  logic                o_id_extop;
  logic                o_illegal;
  logic                o_pc_write;
  logic                o_ifid_write;
  logic                o_ifid_flush;
  logic [1:0]          o_pc_sel;
  logic                o_ex_alusrc;
  logic [ALUCTR_W-1:0] o_ex_aluctr;
  logic [1:0]          o_fwd_a;
  logic [1:0]          o_fwd_b;
  logic                o_mem_memwr;
  logic                o_wb_regwr;
  logic                o_wb_memtoreg;
  logic [RA_W-1:0]     o_wb_waddr;
  modport slave (
    input  i_op, i_funct, i_rs, i_rt, i_rd, i_zero,
    output o_id_extop, o_illegal, o_pc_write, o_ifid_write, o_ifid_flush, o_pc_sel,
           o_ex_alusrc, o_ex_aluctr, o_fwd_a, o_fwd_b, o_mem_memwr,
           o_wb_regwr, o_wb_memtoreg, o_wb_waddr
  );
  modport master (
    output i_op, i_funct, i_rs, i_rt, i_rd, i_zero,
    input  o_id_extop, o_illegal, o_pc_write, o_ifid_write, o_ifid_flush, o_pc_sel,
           o_ex_alusrc, o_ex_aluctr, o_fwd_a, o_fwd_b, o_mem_memwr,
           o_wb_regwr, o_wb_memtoreg, o_wb_waddr
  );
endinterface

// File: rtl/pipe_ctrl_decode.sv
// pipe_ctrl_decode: combinational opcode/funct to control-bundle decoder
//   op, funct : ID-stage instruction fields
//   ctl       : decoded bundle; unknown encodings give a NOP with illegal set
//   PIPE_CTRL_BNE_EN : when defined, bne (0x05) decodes like beq with branch_ne set
module pipe_ctrl_decode
  import pipe_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output ctl_t       ctl
);
  always_comb begin
    ctl = CTL_NOP;
    case (op)
      OP_RTYPE: begin
        ctl.regwr = 1'b1; ctl.regdst = 1'b1; ctl.use_rs = 1'b1; ctl.use_rt = 1'b1;
        case (funct)
          FN_ADDU: ctl.aluctr = ALU_ADDU;
          FN_SUBU: ctl.aluctr = ALU_SUBU;
          FN_AND:  ctl.aluctr = ALU_AND;
          FN_OR:   ctl.aluctr = ALU_OR;
          FN_SLT:  ctl.aluctr = ALU_SLT;
          default: begin ctl = CTL_NOP; ctl.illegal = 1'b1; end
        endcase
      end
      OP_ORI: begin
        ctl.regwr = 1'b1; ctl.alusrc = 1'b1; ctl.aluctr = ALU_OR; ctl.use_rs = 1'b1;
      end
      OP_ADDIU: begin
        ctl.regwr = 1'b1; ctl.alusrc = 1'b1; ctl.extop = 1'b1; ctl.use_rs = 1'b1;
      end
      OP_LW: begin
        ctl.regwr = 1'b1; ctl.memtoreg = 1'b1; ctl.alusrc = 1'b1; ctl.extop = 1'b1; ctl.use_rs = 1'b1;
      end
      OP_SW: begin
        ctl.memwr = 1'b1; ctl.alusrc = 1'b1; ctl.extop = 1'b1; ctl.use_rs = 1'b1; ctl.use_rt = 1'b1;
      end
      OP_BEQ: begin
        ctl.branch = 1'b1; ctl.aluctr = ALU_SUBU; ctl.extop = 1'b1; ctl.use_rs = 1'b1; ctl.use_rt = 1'b1;
      end
`ifdef PIPE_CTRL_BNE_EN
      OP_BNE: begin
        ctl.branch = 1'b1; ctl.branch_ne = 1'b1; ctl.aluctr = ALU_SUBU; ctl.extop = 1'b1;
        ctl.use_rs = 1'b1; ctl.use_rt = 1'b1;
      end
`endif
      OP_J: ctl.jump = 1'b1;
      default: ctl.illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: pipelined control, load-use stall, jump/branch flush and EX forwarding selects
//   clk, rst_n : core clock (rising edge), asynchronous active-low reset
//   bus        : pipe_ctrl_if.slave carrying ID fields, EX zero flag and every stage control output
//   PIPE_CTRL_BNE_EN : enables bne decode (taken on zero flag clear)
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int ALUCTR_W = 3,
  parameter int RA_W     = 5
) (
  input logic       clk,
  input logic       rst_n,
  pipe_ctrl_if.slave bus
);
  ctl_t            ctl_id;
  ex_ctl_t         ex_nx, ctl_ex;
  logic [RA_W-1:0] dest_id, waddr_ex, rs_ex, rt_ex, waddr_mem, waddr_wb;
  logic            wr_id, stall, taken, jump, bubble;
  logic            regwr_mem, memtoreg_mem, memwr_mem, regwr_wb, memtoreg_wb;
  pipe_ctrl_decode u_decode (
    .op    (bus.i_op),
    .funct (bus.i_funct),
    .ctl   (ctl_id)
  );
  // $0 as destination never writes, and non-writers carry waddr 0 so they never hazard or forward
  assign dest_id = ctl_id.regdst ? bus.i_rd : bus.i_rt;
  assign wr_id   = ctl_id.regwr && dest_id != '0;
  assign ex_nx   = '{regwr: wr_id, memtoreg: ctl_id.memtoreg, memwr: ctl_id.memwr,
                     alusrc: ctl_id.alusrc, aluctr: ctl_id.aluctr,
                     branch: ctl_id.branch, branch_ne: ctl_id.branch_ne};
  assign taken  = ctl_ex.branch && (ctl_ex.branch_ne ^ bus.i_zero);
  assign stall  = ctl_ex.memtoreg && waddr_ex != '0 &&
                  ((ctl_id.use_rs && bus.i_rs == waddr_ex) || (ctl_id.use_rt && bus.i_rt == waddr_ex));
  // jump is gated by reset so pc_sel/flush read 0 while reset is held
  assign jump   = rst_n && ctl_id.jump;
  assign bubble = stall || taken;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ctl_ex   <= EX_NOP;
      waddr_ex <= '0;
      rs_ex    <= '0;
      rt_ex    <= '0;
    end else begin
      ctl_ex   <= bubble ? EX_NOP : ex_nx;
      waddr_ex <= bubble || !wr_id ? '0 : dest_id;
      rs_ex    <= bubble ? '0 : bus.i_rs;
      rt_ex    <= bubble ? '0 : bus.i_rt;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      regwr_mem    <= 1'b0;
      memtoreg_mem <= 1'b0;
      memwr_mem    <= 1'b0;
      waddr_mem    <= '0;
      regwr_wb     <= 1'b0;
      memtoreg_wb  <= 1'b0;
      waddr_wb     <= '0;
    end else begin
      regwr_mem    <= ctl_ex.regwr;
      memtoreg_mem <= ctl_ex.memtoreg;
      memwr_mem    <= ctl_ex.memwr;
      waddr_mem    <= waddr_ex;
      regwr_wb     <= regwr_mem;
      memtoreg_wb  <= memtoreg_mem;
      waddr_wb     <= waddr_mem;
    end
  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] r, input logic rw_m,
                                         input logic [RA_W-1:0] wa_m, input logic rw_w,
                                         input logic [RA_W-1:0] wa_w);
    return r == '0 ? FWD_RF : rw_m && wa_m == r ? FWD_EXMEM : rw_w && wa_w == r ? FWD_MEMWB : FWD_RF;
  endfunction
  assign bus.o_fwd_a       = fwd_sel(rs_ex, regwr_mem, waddr_mem, regwr_wb, waddr_wb);
  assign bus.o_fwd_b       = fwd_sel(rt_ex, regwr_mem, waddr_mem, regwr_wb, waddr_wb);
  assign bus.o_id_extop    = ctl_id.extop;
  assign bus.o_illegal     = ctl_id.illegal;
  assign bus.o_pc_write    = !stall || taken;
  assign bus.o_ifid_write  = !stall || taken;
  assign bus.o_pc_sel      = taken ? PC_BRANCH : stall ? PC_PLUS4 : jump ? PC_JUMP : PC_PLUS4;
  assign bus.o_ifid_flush  = taken || (!stall && jump);
  assign bus.o_ex_alusrc   = ctl_ex.alusrc;
  assign bus.o_ex_aluctr   = ALUCTR_W'(ctl_ex.aluctr);
  assign bus.o_mem_memwr   = memwr_mem;
  assign bus.o_wb_regwr    = regwr_wb;
  assign bus.o_wb_memtoreg = memtoreg_wb;
  assign bus.o_wb_waddr    = waddr_wb;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: directed and random checks of pipe_ctrl_unit against an instruction-level pipeline model
module tb_pipe_ctrl_unit;
  typedef struct packed {
    logic load, store, br, bne, wr, alusrc, use_rs, use_rt, extop, jump, illegal;
    logic [2:0] alu;
    logic [4:0] dest, rs, rt;
  } ins_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  pipe_ctrl_if bus ();
  pipe_ctrl_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  ins_t ex, mem, wb, ex_n, cur;
  logic hz = 1'b0;
  logic tk = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [5:0] ops [9];
  logic [5:0] fns [6];
  function automatic ins_t info(input logic [5:0] op, fn, input logic [4:0] rs, rt, rd);
    ins_t d = '0;
    d.rs = rs;
    d.rt = rt;
    if (op == 6'h00) begin
      if (fn == 6'h21 || fn == 6'h23 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2a) begin
        d.wr = 1; d.dest = rd; d.use_rs = 1; d.use_rt = 1;
        d.alu = fn == 6'h21 ? 3'd0 : fn == 6'h23 ? 3'd1 : fn == 6'h24 ? 3'd3 : fn == 6'h25 ? 3'd2 : 3'd4;
      end else d.illegal = 1;
    end else if (op == 6'h0d) begin
      d.wr = 1; d.dest = rt; d.use_rs = 1; d.alusrc = 1; d.alu = 3'd2;
    end else if (op == 6'h09) begin
      d.wr = 1; d.dest = rt; d.use_rs = 1; d.alusrc = 1; d.extop = 1;
    end else if (op == 6'h23) begin
      d.load = 1; d.wr = 1; d.dest = rt; d.use_rs = 1; d.alusrc = 1; d.extop = 1;
    end else if (op == 6'h2b) begin
      d.store = 1; d.use_rs = 1; d.use_rt = 1; d.alusrc = 1; d.extop = 1;
    end else if (op == 6'h04) begin
      d.br = 1; d.use_rs = 1; d.use_rt = 1; d.extop = 1; d.alu = 3'd1;
`ifdef PIPE_CTRL_BNE_EN
    end else if (op == 6'h05) begin
      d.br = 1; d.bne = 1; d.use_rs = 1; d.use_rt = 1; d.extop = 1; d.alu = 3'd1;
`endif
    end else if (op == 6'h02) d.jump = 1;
    else d.illegal = 1;
    if (d.dest == 0) d.wr = 0;
    if (!d.wr) d.dest = 0;
    return d;
  endfunction
  function automatic logic [1:0] fwd(input logic [4:0] r);
    return r == 0 ? 2'd0 : (mem.wr && mem.dest == r) ? 2'd2 : (wb.wr && wb.dest == r) ? 2'd1 : 2'd0;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [5:0] op, fn, input logic [4:0] rs, rt, rd, input logic z);
    @(negedge clk);
    bus.i_op = op; bus.i_funct = fn; bus.i_rs = rs; bus.i_rt = rt; bus.i_rd = rd; bus.i_zero = z;
    #1;
    cur = info(op, fn, rs, rt, rd);
    tk = ex.br && (ex.bne ? !z : z);
    hz = ex.load && ex.dest != 0 && ((cur.use_rs && cur.rs == ex.dest) || (cur.use_rt && cur.rt == ex.dest));
    chk("pc_write", 32'(bus.o_pc_write), 32'(!(hz && !tk)));
    chk("ifid_write", 32'(bus.o_ifid_write), 32'(!(hz && !tk)));
    chk("pc_sel", 32'(bus.o_pc_sel), tk ? 1 : hz ? 0 : cur.jump ? 2 : 0);
    chk("ifid_flush", 32'(bus.o_ifid_flush), 32'(tk || (!hz && cur.jump)));
    chk("fwd_a", 32'(bus.o_fwd_a), 32'(fwd(ex.rs)));
    chk("fwd_b", 32'(bus.o_fwd_b), 32'(fwd(ex.rt)));
    chk("ex_alusrc", 32'(bus.o_ex_alusrc), 32'(ex.alusrc));
    chk("ex_aluctr", 32'(bus.o_ex_aluctr), 32'(ex.alu));
    chk("mem_memwr", 32'(bus.o_mem_memwr), 32'(mem.store));
    chk("wb_regwr", 32'(bus.o_wb_regwr), 32'(wb.wr));
    chk("wb_memtoreg", 32'(bus.o_wb_memtoreg), 32'(wb.load));
    chk("wb_waddr", 32'(bus.o_wb_waddr), 32'(wb.dest));
    chk("id_extop", 32'(bus.o_id_extop), 32'(cur.extop));
    chk("illegal", 32'(bus.o_illegal), 32'(cur.illegal));
    ex_n = (hz || tk) ? '0 : cur;
  endtask
  task automatic tick();
    @(posedge clk);
    wb = mem;
    mem = ex;
    ex = ex_n;
  endtask
  task automatic nop();
    drive(6'h0d, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask
  task automatic hit_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_pc_write", 32'(bus.o_pc_write), 1);
    chk("rst_ifid_write", 32'(bus.o_ifid_write), 1);
    chk("rst_flush", 32'(bus.o_ifid_flush), 0);
    chk("rst_pc_sel", 32'(bus.o_pc_sel), 0);
    chk("rst_fwd_a", 32'(bus.o_fwd_a), 0);
    chk("rst_fwd_b", 32'(bus.o_fwd_b), 0);
    chk("rst_alusrc", 32'(bus.o_ex_alusrc), 0);
    chk("rst_aluctr", 32'(bus.o_ex_aluctr), 0);
    chk("rst_memwr", 32'(bus.o_mem_memwr), 0);
    chk("rst_regwr", 32'(bus.o_wb_regwr), 0);
    chk("rst_memtoreg", 32'(bus.o_wb_memtoreg), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ex = '0; mem = '0; wb = '0; ex_n = '0; hz = 1'b0; tk = 1'b0;
  endtask
  initial begin
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;
    ops = '{6'h00, 6'h0d, 6'h09, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h3f};
    fns = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2a, 6'h00};
    bus.i_op = 6'h02; bus.i_funct = 6'h00; bus.i_rs = 5'd0; bus.i_rt = 5'd0; bus.i_rd = 5'd0; bus.i_zero = 1'b0;
    ex = '0; mem = '0; wb = '0; ex_n = '0;
    #2;
    hit_reset();
    // load-use: lw $8,0($0) ; addu $9,$8,$8
    drive(6'h23, 6'h00, 5'd0, 5'd8, 5'd0, 1'b0); tick();
    drive(6'h00, 6'h21, 5'd8, 5'd8, 5'd9, 1'b0);
    chk("lu_stall_pc_write", 32'(bus.o_pc_write), 0);
    chk("lu_stall_ifid_write", 32'(bus.o_ifid_write), 0);
    tick();
    drive(6'h00, 6'h21, 5'd8, 5'd8, 5'd9, 1'b0);
    chk("lu_bubble_aluctr", 32'(bus.o_ex_aluctr), 0);
    chk("lu_release", 32'(bus.o_pc_write), 1);
    tick();
    nop();
    chk("lu_fwd_a", 32'(bus.o_fwd_a), 1);
    chk("lu_fwd_b", 32'(bus.o_fwd_b), 1);
    tick();
    // forwarding: addu $3,$1,$2 ; subu $4,$3,$3
    drive(6'h00, 6'h21, 5'd1, 5'd2, 5'd3, 1'b0); tick();
    drive(6'h00, 6'h23, 5'd3, 5'd3, 5'd4, 1'b0); tick();
    nop();
    chk("fw_fwd_a", 32'(bus.o_fwd_a), 2);
    chk("fw_fwd_b", 32'(bus.o_fwd_b), 2);
    chk("fw_aluctr", 32'(bus.o_ex_aluctr), 1);
    tick();
    // taken beq in EX beats j in ID
    drive(6'h04, 6'h00, 5'd1, 5'd2, 5'd0, 1'b0); tick();
    drive(6'h02, 6'h00, 5'd0, 5'd0, 5'd0, 1'b1);
    chk("br_pc_sel", 32'(bus.o_pc_sel), 1);
    chk("br_flush", 32'(bus.o_ifid_flush), 1);
    tick();
    nop(); tick();
    // ori $0,$1,5 then a consumer of $0
    drive(6'h0d, 6'h00, 5'd1, 5'd0, 5'd0, 1'b0); tick();
    drive(6'h00, 6'h21, 5'd0, 5'd0, 5'd5, 1'b0); tick();
    nop();
    chk("r0_fwd_a", 32'(bus.o_fwd_a), 0);
    tick();
    nop();
    chk("r0_wb_regwr", 32'(bus.o_wb_regwr), 0);
    tick();
    // bne with zero clear
    drive(6'h05, 6'h00, 5'd1, 5'd2, 5'd0, 1'b0);
`ifdef PIPE_CTRL_BNE_EN
    chk("bne_illegal", 32'(bus.o_illegal), 0);
`else
    chk("bne_illegal", 32'(bus.o_illegal), 1);
`endif
    tick();
    nop();
`ifdef PIPE_CTRL_BNE_EN
    chk("bne_pc_sel", 32'(bus.o_pc_sel), 1);
`else
    chk("bne_pc_sel", 32'(bus.o_pc_sel), 0);
`endif
    tick();
    // reset with a jump in ID, and reset in the middle of a stall
    drive(6'h02, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    hit_reset();
    drive(6'h23, 6'h00, 5'd0, 5'd8, 5'd0, 1'b0); tick();
    drive(6'h00, 6'h21, 5'd8, 5'd8, 5'd9, 1'b0);
    hit_reset();
    op = 6'h0d; fn = 6'h00; rs = 5'd0; rt = 5'd0; rd = 5'd0;
    for (int n = 0; n < 600; n++) begin
      if (!(hz && !tk)) begin
        op = ops[$urandom_range(0, 8)];
        fn = fns[$urandom_range(0, 5)];
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 3));
      end
      drive(op, fn, rs, rt, rd, 1'($urandom_range(0, 1)));
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Pipelined control and hazard unit for the five-stage MIPS-subset core. Decodes the ID-stage opcode/funct into a control bundle and carries it through ID/EX, EX/MEM and MEM/WB control registers. Also detects load-use hazards (stall), resolves jumps in ID and taken branches in EX (flush), and generates forwarding selects for the EX-stage ALU operands. It replaces the single-cycle combinational decoder; datapath registers stay outside this block.

## Interface
- `ALUCTR_W`, default 3: ALU control width; must be ≥ 3, upper bits zero-filled.
- `RA_W`, default 5: register-address width.
- `clk` input 1: core clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `i_op` input 6: ID-stage opcode.
- `i_funct` input 6: ID-stage funct.
- `i_rs`, `i_rt`, `i_rd` input RA_W each: ID-stage register fields.
- `i_zero` input 1: ALU zero flag from the EX stage.
- `o_id_extop` output 1: combinational sign-extend select for the ID immediate.
- `o_illegal` output 1: combinational flag for an unknown ID opcode or funct.
- `o_pc_write`, `o_ifid_write`, `o_ifid_flush` output 1 each: IF-stage control.
- `o_pc_sel` output 2: 00 = PC+4, 01 = branch target, 10 = jump target.
- `o_ex_alusrc` output 1: EX-stage ALU operand-B immediate select.
- `o_ex_aluctr` output ALUCTR_W: EX-stage ALU operation.
- `o_fwd_a`, `o_fwd_b` output 2 each: 00 = register file, 01 = MEM/WB, 10 = EX/MEM.
- `o_mem_memwr` output 1: data-memory write.
- `o_wb_regwr`, `o_wb_memtoreg` output 1 each: write-back controls.
- `o_wb_waddr` output RA_W: write-back register address.

## Operation
- **Supported instructions:** addu, subu, and, or, slt (R-type, op 0); ori (0x0D), addiu (0x09), lw (0x23), sw (0x2B), beq (0x04), j (0x02).
- **Unknown op/funct:** decodes as a NOP (all write enables 0) and asserts `o_illegal`.
- **ALU op encoding:** ADDU=0, SUBU=1, OR=2, AND=3, SLT=4.
  - lw, sw and addiu use ADDU; beq uses SUBU; ori uses OR.
- **ExtOp:** 1 for addiu, lw, sw and beq.
- **Register destination:** `rd` for R-type, `rt` for ori/addiu/lw.
  - The destination is resolved in ID and stored as `waddr` in ID/EX.
  - A destination of 0 forces `regwr` to 0.
- **Operand usage:** R-type, beq and sw use both rs and rt. ori, addiu and lw use rs only. j uses neither.
- **Load-use stall:** raised when ID/EX holds a lw, its `waddr` ≠ 0, and `waddr` matches an ID field that is actually used.
  - `o_pc_write` = 0 and `o_ifid_write` = 0.
  - ID/EX loads a bubble (all enables 0).
- **Jump in ID:** `o_pc_sel` = 10, `o_ifid_flush` = 1. The jump itself proceeds as a NOP.
- **Taken branch in EX:** ID/EX holds beq and `i_zero` = 1.
  - `o_pc_sel` = 01, `o_ifid_flush` = 1, ID/EX loads a bubble.
- **Priority:** taken branch > load-use stall > jump.
  - A stall and a taken branch cannot coexist, but the branch still wins by construction.
- **Forwarding (operand A; same rules for B with rt):**
  - 10 if EX/MEM `regwr` and EX/MEM `waddr` == ID/EX rs.
  - Otherwise 01 if the same condition holds for MEM/WB.
  - Otherwise 00.
  - Register 0 is never forwarded.

## Timing
- **Reset values:**
  - All pipeline control registers clear to NOP.
  - All stage outputs are 0: `o_fwd_*` = 00, `o_pc_sel` = 00.
  - `o_pc_write` = 1, `o_ifid_write` = 1, `o_ifid_flush` = 0.
- **Decode to EX:** 1 cycle. Decode to MEM: 2 cycles. Decode to WB: 3 cycles.
- **Combinational outputs:** stall, flush and `pc_sel` are combinational in the same cycle as the triggering condition.
- **Stall length:** exactly one bubble per load-use hazard.
- **Reset mid-stall or mid-flush:** returns to the reset values immediately (asynchronous).

## Configuration
- **`PIPE_CTRL_BNE_EN` defined:**
  - bne (0x05) is decoded with the same controls as beq.
  - It is taken when `i_zero` = 0; ID/EX carries a `branch_ne` bit.
- **`PIPE_CTRL_BNE_EN` undefined:** 0x05 is illegal and decodes as a NOP.

## Structure
- **Package `pipe_ctrl_pkg`:**
  - opcode/funct constants
  - ALU op constants
  - forwarding and `pc_sel` encodings
  - the packed control-bundle typedef
- **Sub-module `pipe_ctrl_decode`:** purely combinational op/funct to bundle decoder. Stage registers, hazard and forwarding logic live in the top level.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-stream → all WB/MEM/EX enables 0, `o_pc_write` = 1, `o_fwd_a` = 00 immediately.
- **Load-use:** `lw $8,0($0)` then `addu $9,$8,$8` → one cycle with `o_pc_write` = 0 and a bubble in EX; next cycle `o_fwd_a` = `o_fwd_b` = 01.
- **Forwarding:** `addu $3,$1,$2` then `subu $4,$3,$3` → in EX of subu, `o_fwd_a` = `o_fwd_b` = 10, `o_ex_aluctr` = 1.
- **Taken branch:** beq with `i_zero` = 1 in EX and j in ID → `o_pc_sel` = 01 and ID/EX bubbled; the jump is suppressed.
- **$0 destination:** `ori $0,$1,5` → `o_wb_regwr` = 0; a following consumer of `$0` gets `o_fwd_a` = 00.
- **bne:** op 0x05 with `i_zero` = 0 → `o_pc_sel` = 01 when `PIPE_CTRL_BNE_EN` is defined; otherwise `o_illegal` = 1 and no writes.
